// File: rtl/pong_ball_engine.sv
// pong_ball_engine: ball physics and scoring for the two-player pong game.
// Moves the ball once per game tick. Wall, paddle and goal events are
// resolved in that priority order. The engine also keeps score, serves
// after each point and declares the winner.
// Ports:
//   clk, reset (async, active-low)   clock and reset
//   tick                             one-cycle game-update strobe
//   start                            level; starts or restarts a game
//   pad1_y, pad2_y                   paddle top edges (left, right)
//   ball_x, ball_y                   ball top-left corner to the renderer
//   score1, score2                   player scores
//   game_over, hit, point            status flag and one-cycle event pulses
//   state_o                          FSM state encoding for the SSD
module pong_ball_engine #(
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int X_W         = 11,
  parameter int Y_W         = 10,
  parameter int BALL_SIZE   = 10,
  parameter int PAD_W       = 10,
  parameter int PAD_H       = 50,
  parameter int PAD1_X      = 20,
  parameter int PAD2_X      = 620,
  parameter int SPD_W       = 4,
  parameter int INIT_SPEED  = 2,
  parameter int MAX_SPEED   = 8,
  parameter int SCORE_W     = 4,
  parameter int WIN_SCORE   = 9,
  parameter int SERVE_TICKS = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               start,
  input  logic [Y_W-1:0]     pad1_y,
  input  logic [Y_W-1:0]     pad2_y,
  output logic [X_W-1:0]     ball_x,
  output logic [Y_W-1:0]     ball_y,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic               game_over,
  output logic               hit,
  output logic               point,
  output logic [2:0]         state_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SERVE   = 3'd1,
    PLAY    = 3'd2,
    UPDATE  = 3'd3,
    COLLIDE = 3'd4,
    OVER    = 3'd5
  } state_t;

  localparam int XE    = X_W + 1;
  localparam int YE    = Y_W + 1;
  localparam int CNT_W = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;

  localparam logic [X_W-1:0]     CX       = X_W'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [Y_W-1:0]     CY       = Y_W'((SCREEN_H - BALL_SIZE) / 2);
  localparam logic [X_W-1:0]     X_MAX    = X_W'(SCREEN_W - BALL_SIZE);
  localparam logic [Y_W-1:0]     Y_MAX    = Y_W'(SCREEN_H - BALL_SIZE);
  localparam logic [XE-1:0]      P1_L     = XE'(PAD1_X);
  localparam logic [XE-1:0]      P1_R     = XE'(PAD1_X + PAD_W);
  localparam logic [XE-1:0]      P2_L     = XE'(PAD2_X);
  localparam logic [XE-1:0]      P2_R     = XE'(PAD2_X + PAD_W);
  localparam logic [X_W-1:0]     P1_SNAP  = X_W'(PAD1_X + PAD_W);
  localparam logic [X_W-1:0]     P2_SNAP  = X_W'(PAD2_X - BALL_SIZE);
  localparam logic [SPD_W-1:0]   SPD_INIT = SPD_W'(INIT_SPEED);
  localparam logic [SPD_W-1:0]   SPD_MAX  = SPD_W'(MAX_SPEED);
  localparam logic [SCORE_W-1:0] SC_WIN   = SCORE_W'(WIN_SCORE);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SERVE_TICKS - 1);

  state_t             state;
  logic               dir_x;   // 1 = right
  logic               dir_y;   // 1 = down
  logic [SPD_W-1:0]   spd_x;
  logic [SPD_W-1:0]   spd_y;
  logic [CNT_W-1:0]   serve_cnt;
  logic [Y_W-1:0]     pad1_q;
  logic [Y_W-1:0]     pad2_q;

  logic [XE-1:0]      x_ext, x_sum, x_right;
  logic [YE-1:0]      y_ext, y_sum, y_bot, y_mid;
  logic [X_W-1:0]     x_next;
  logic [Y_W-1:0]     y_next;
  logic [YE-1:0]      p1_top, p2_top;
  logic               hit1, hit2, p1_above, p2_above, goal1, goal2;
  logic [SPD_W-1:0]   spd_inc;
  logic [SCORE_W-1:0] s1_inc, s2_inc;

  assign state_o = state;

  always_comb begin
    x_ext   = {1'b0, ball_x};
    y_ext   = {1'b0, ball_y};
    x_sum   = x_ext + XE'(spd_x);
    y_sum   = y_ext + YE'(spd_y);
    x_right = x_ext + XE'(BALL_SIZE);
    y_bot   = y_ext + YE'(BALL_SIZE);
    y_mid   = y_ext + YE'(BALL_SIZE / 2);
    p1_top  = {1'b0, pad1_q};
    p2_top  = {1'b0, pad2_q};

    // One-bit-wider sums keep the clamp free of wrap-around.
    if (!dir_x) x_next = (ball_x <= X_W'(spd_x)) ? '0 : ball_x - X_W'(spd_x);
    else        x_next = (x_sum > {1'b0, X_MAX}) ? X_MAX : x_sum[X_W-1:0];
    if (!dir_y) y_next = (ball_y <= Y_W'(spd_y)) ? '0 : ball_y - Y_W'(spd_y);
    else        y_next = (y_sum > {1'b0, Y_MAX}) ? Y_MAX : y_sum[Y_W-1:0];

    hit1 = !dir_x && (x_ext <= P1_R) && (x_right > P1_L) &&
           (y_bot > p1_top) && (y_ext < p1_top + YE'(PAD_H));
    hit2 = dir_x && (x_right >= P2_L) && (x_ext < P2_R) &&
           (y_bot > p2_top) && (y_ext < p2_top + YE'(PAD_H));
    p1_above = y_mid < p1_top + YE'(PAD_H / 2);
    p2_above = y_mid < p2_top + YE'(PAD_H / 2);
    goal2    = (ball_x == '0);
    goal1    = (ball_x == X_MAX);
    spd_inc  = (spd_x >= SPD_MAX) ? SPD_MAX : spd_x + SPD_W'(1);
    s1_inc   = (score1 >= SC_WIN) ? SC_WIN : score1 + SCORE_W'(1);
    s2_inc   = (score2 >= SC_WIN) ? SC_WIN : score2 + SCORE_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      ball_x    <= CX;
      ball_y    <= CY;
      score1    <= '0;
      score2    <= '0;
      dir_x     <= 1'b1;
      dir_y     <= 1'b1;
      spd_x     <= SPD_INIT;
      spd_y     <= SPD_INIT;
      serve_cnt <= '0;
      pad1_q    <= '0;
      pad2_q    <= '0;
      hit       <= 1'b0;
      point     <= 1'b0;
      game_over <= 1'b0;
    end else begin
      hit   <= 1'b0;
      point <= 1'b0;
      case (state)
        IDLE: begin
          ball_x <= CX;
          ball_y <= CY;
          spd_x  <= SPD_INIT;
          spd_y  <= SPD_INIT;
          if (start) begin
            score1    <= '0;
            score2    <= '0;
            serve_cnt <= '0;
            state     <= SERVE;
          end
        end
        SERVE: begin
          if (tick) begin
            if (serve_cnt == CNT_LAST) state <= PLAY;
            else                       serve_cnt <= serve_cnt + CNT_W'(1);
          end
        end
        PLAY: begin
          if (tick) state <= UPDATE;
        end
        UPDATE: begin
          ball_x <= x_next;
          ball_y <= y_next;
          pad1_q <= pad1_y;
          pad2_q <= pad2_y;
          state  <= COLLIDE;
        end
        COLLIDE: begin
          state <= PLAY;
          // Wall reflection is written first so that a paddle hit in the
          // same cycle can override dir_y while still sharing the event.
          if (ball_y == '0)        dir_y <= 1'b1;
          else if (ball_y == Y_MAX) dir_y <= 1'b0;
          if (hit1) begin
            dir_x  <= 1'b1;
            ball_x <= P1_SNAP;
            spd_x  <= spd_inc;
            dir_y  <= !p1_above;
            hit    <= 1'b1;
          end else if (hit2) begin
            dir_x  <= 1'b0;
            ball_x <= P2_SNAP;
            spd_x  <= spd_inc;
            dir_y  <= !p2_above;
            hit    <= 1'b1;
          end else if (goal2 || goal1) begin
            point <= 1'b1;
            if (goal2) score2 <= s2_inc;
            else       score1 <= s1_inc;
            if ((goal2 ? s2_inc : s1_inc) == SC_WIN) begin
              state     <= OVER;
              game_over <= 1'b1;
            end else begin
              ball_x    <= CX;
              ball_y    <= CY;
              spd_x     <= SPD_INIT;
              spd_y     <= SPD_INIT;
              dir_x     <= goal1;   // serve toward the player who conceded
              serve_cnt <= '0;
              state     <= SERVE;
            end
          end
        end
        OVER: begin
          if (start) begin
            state     <= IDLE;
            game_over <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pong_ball_engine.sv
module tb_pong_ball_engine;

  localparam int XMAX = 630;
  localparam int YMAX = 470;

  logic       clk = 1'b0;
  logic       reset, tick, start;
  logic [9:0] pad1_y, pad2_y;
  logic [10:0] ball_x;
  logic [9:0]  ball_y;
  logic [3:0]  score1, score2;
  logic        game_over, hit, point;
  logic [2:0]  state_o;

  always #5 clk = ~clk;

  pong_ball_engine #(.SCREEN_W(640), .SCREEN_H(480), .SERVE_TICKS(32), .WIN_SCORE(9)) dut (
    .clk(clk), .reset(reset), .tick(tick), .start(start),
    .pad1_y(pad1_y), .pad2_y(pad2_y),
    .ball_x(ball_x), .ball_y(ball_y), .score1(score1), .score2(score2),
    .game_over(game_over), .hit(hit), .point(point), .state_o(state_o)
  );

  typedef struct { int x; int y; int s1; int s2; int hit; int point; int over; int st; } exp_t;
  exp_t q[$];

  int checks = 0;
  int failures = 0;
  int events = 0;
  int prev_st = 0;
  int mon_hit = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=bound_expired required=event", name);
  endtask

  // Monitor: the cycle after COLLIDE is when a move result is presented.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) prev_st = 0;
    else begin
      if (hit || point) begin
        checks++;
        if (prev_st != 4) begin
          failures++;
          $display("FAIL pulse_timing actual=hit%0d_point%0d_outside_result required=none", hit, point);
        end
      end
      if (prev_st == 4) begin
        events++;
        mon_hit = int'(hit);
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_result actual=x%0d required=no_result", ball_x);
        end else begin
          e = q.pop_front();
          if (int'(ball_x) != e.x || int'(ball_y) != e.y || int'(score1) != e.s1 ||
              int'(score2) != e.s2 || int'(hit) != e.hit || int'(point) != e.point ||
              int'(game_over) != e.over || int'(state_o) != e.st) begin
            failures++;
            $display("FAIL move_result actual=x%0d y%0d s%0d/%0d h%0d p%0d o%0d st%0d required=x%0d y%0d s%0d/%0d h%0d p%0d o%0d st%0d",
                     ball_x, ball_y, score1, score2, hit, point, game_over, state_o,
                     e.x, e.y, e.s1, e.s2, e.hit, e.point, e.over, e.st);
          end
        end
      end
      prev_st = int'(state_o);
    end
  end

  // Reference model of the game, advanced once per issued tick.
  int m_state, m_x, m_y, m_dx, m_dy, m_sx, m_sy, m_s1, m_s2, m_cnt;
  int m_hit, m_point;
  int p1_mode = 0, p2_mode = 0;   // 1 = track the ball, 0 = stay clear

  task automatic model_init();
    m_state = 0; m_x = 315; m_y = 235; m_dx = 1; m_dy = 1;
    m_sx = 2; m_sy = 2; m_s1 = 0; m_s2 = 0; m_cnt = 0;
  endtask

  task automatic model_serve();
    m_state = 1; m_cnt = 0; m_s1 = 0; m_s2 = 0;
    m_x = 315; m_y = 235; m_sx = 2; m_sy = 2;
  endtask

  task automatic model_tick(input int p1, input int p2);
    exp_t e;
    int nx, ny, ns;
    m_hit = 0; m_point = 0;
    if (m_state == 1) begin
      if (m_cnt == 31) m_state = 2; else m_cnt++;
    end else if (m_state == 2) begin
      nx = m_x + m_dx * m_sx;
      ny = m_y + m_dy * m_sy;
      if (nx < 0) nx = 0;
      if (nx > XMAX) nx = XMAX;
      if (ny < 0) ny = 0;
      if (ny > YMAX) ny = YMAX;
      m_state = 2;
      if (ny == 0) m_dy = 1;
      else if (ny == YMAX) m_dy = -1;
      if (m_dx < 0 && nx <= 30 && nx + 10 > 20 && ny + 10 > p1 && ny < p1 + 50) begin
        m_dx = 1; nx = 30; m_sx = (m_sx + 1 > 8) ? 8 : m_sx + 1;
        m_dy = (ny + 5 < p1 + 25) ? -1 : 1; m_hit = 1;
      end else if (m_dx > 0 && nx + 10 >= 620 && nx < 630 && ny + 10 > p2 && ny < p2 + 50) begin
        m_dx = -1; nx = 610; m_sx = (m_sx + 1 > 8) ? 8 : m_sx + 1;
        m_dy = (ny + 5 < p2 + 25) ? -1 : 1; m_hit = 1;
      end else if (nx == 0 || nx == XMAX) begin
        m_point = 1;
        if (nx == 0) begin m_s2 = (m_s2 < 9) ? m_s2 + 1 : 9; ns = m_s2; end
        else         begin m_s1 = (m_s1 < 9) ? m_s1 + 1 : 9; ns = m_s1; end
        if (ns == 9) m_state = 5;
        else begin
          m_dx = (nx == 0) ? -1 : 1;
          nx = 315; ny = 235; m_sx = 2; m_sy = 2; m_cnt = 0; m_state = 1;
        end
      end
      m_x = nx; m_y = ny;
      e.x = m_x; e.y = m_y; e.s1 = m_s1; e.s2 = m_s2;
      e.hit = m_hit; e.point = m_point; e.over = (m_state == 5) ? 1 : 0; e.st = m_state;
      q.push_back(e);
    end
  endtask

  function automatic int pad_pos(input int mode, input int y);
    int p;
    if (mode == 1) begin
      p = y - 20;
      if (p < 0) p = 0;
      if (p > 430) p = 430;
    end else p = (y > 240) ? 0 : 430;
    return p;
  endfunction

  task automatic do_tick();
    int p1, p2;
    p1 = pad_pos(p1_mode, m_y);
    p2 = pad_pos(p2_mode, m_y);
    @(negedge clk);
    pad1_y = 10'(p1);
    pad2_y = 10'(p2);
    tick = 1'b1;
    model_tick(p1, p2);
    @(negedge clk);
    tick = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int n, ev0, fy;
    reset = 1'b0; tick = 1'b0; start = 1'b0; pad1_y = '0; pad2_y = '0;
    model_init();
    repeat (3) @(negedge clk);
    chk("rst_state", state_o, 0);
    chk("rst_x", ball_x, 315);
    chk("rst_y", ball_y, 235);
    chk("rst_scores", {score1, score2}, 0);
    chk("rst_flags", {hit, point, game_over}, 0);
    reset = 1'b1;

    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    model_serve();
    chk("serve_entry", state_o, 1);
    repeat (31) do_tick();
    chk("serve_hold_31", state_o, 1);
    do_tick();
    chk("serve_to_play", state_o, 2);

    p1_mode = 0; p2_mode = 1;
    do_tick();
    chk("first_move_x", ball_x, 317);
    chk("first_move_y", ball_y, 235 + 2);

    n = 0;
    while (m_hit == 0 && n < 400) begin do_tick(); n++; end
    if (m_hit == 0) bound_fail("reach_paddle2");
    chk("paddle2_snap", ball_x, 610);

    p2_mode = 0;
    n = 0;
    while (m_point == 0 && n < 400) begin do_tick(); n++; end
    if (m_point == 0) bound_fail("reach_left_goal");
    chk("goal2_score", score2, 1);
    chk("goal2_recentre_x", ball_x, 315);
    chk("goal2_recentre_y", ball_y, 235);
    chk("goal2_to_serve", state_o, 1);

    p1_mode = 1;
    repeat (32) do_tick();
    repeat (142) do_tick();
    chk("approach_x", ball_x, 31);
    do_tick();
    chk("paddle1_snap", ball_x, 30);
    chk("paddle1_hit", mon_hit, 1);
    p1_mode = 0;
    do_tick();
    chk("after_hit_speed3", ball_x, 33);

    n = 0;
    while (m_state != 5 && n < 4000) begin do_tick(); n++; end
    if (m_state != 5) bound_fail("reach_win");
    chk("win_score1", score1, 9);
    chk("win_score2", score2, 1);
    chk("win_game_over", game_over, 1);
    chk("win_state", state_o, 5);
    chk("win_x", ball_x, 630);
    fy = m_y;
    repeat (4) do_tick();
    chk("frozen_x", ball_x, 630);
    chk("frozen_y", ball_y, fy);

    @(negedge clk) start = 1'b1;
    @(negedge clk);
    chk("restart_idle", state_o, 0);
    chk("restart_over_clr", game_over, 0);
    @(negedge clk) start = 1'b0;
    model_serve();
    chk("restart_serve", state_o, 1);
    chk("restart_scores", {score1, score2}, 0);

    repeat (32) do_tick();
    n = 0;
    while (m_point == 0 && n < 400) begin do_tick(); n++; end
    if (m_point == 0) bound_fail("reach_right_goal");
    chk("goal1_score", score1, 1);

    repeat (32) do_tick();
    n = 0;
    while (m_x < 628 && n < 400) begin do_tick(); n++; end
    if (m_x < 628) bound_fail("near_goal");
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
    chk("abort_in_update", state_o, 3);
    #1 reset = 1'b0;
    q.delete();
    repeat (3) begin
      @(negedge clk);
      chk("abort_point", point, 0);
    end
    chk("abort_state", state_o, 0);
    chk("abort_scores", {score1, score2}, 0);
    chk("abort_x", ball_x, 315);
    reset = 1'b1;
    model_init();

    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    model_serve();
    repeat (32) do_tick();
    ev0 = events;
    @(negedge clk) begin tick = 1'b1; model_tick(pad_pos(0, m_y), pad_pos(0, m_y)); end
    @(negedge clk) tick = 1'b0;
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
    repeat (4) @(negedge clk);
    chk("double_tick_moves", events - ev0, 1);
    do_tick();
    chk("queue_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pong_ball_engine.md
Name: pong_ball_engine

Overview:
- Parametrised ball-physics and scoring engine for the two-player pong game; successor to the fixed-size ball/paddle update logic in the game top level.
- Advances the ball once per game tick. Resolves wall, paddle and goal events in a fixed priority order, then keeps score and serves.
- Speeds up the ball on each paddle hit and declares a winner.
- Outputs the ball position to the object renderer, and scores and events to the SSD/LED logic. Paddle Y positions come from the scaled potentiometer path.

Parameters:
- SCREEN_W, 640: playfield width in pixels.
- SCREEN_H, 480: playfield height in pixels.
- X_W, 11: width of X coordinates.
- Y_W, 10: width of Y coordinates.
- BALL_SIZE, 10: ball width and height.
- PAD_W, 10: paddle width.
- PAD_H, 50: paddle height.
- PAD1_X, 20: left edge of the player-1 (left) paddle.
- PAD2_X, 620: left edge of the player-2 (right) paddle.
- SPD_W, 4: width of the speed registers.
- INIT_SPEED, 2: X and Y speed after each serve.
- MAX_SPEED, 8: saturation value for X speed.
- SCORE_W, 4: width of each score counter.
- WIN_SCORE, 9: score that ends the game.
- SERVE_TICKS, 32: number of ticks the ball is held at centre before a serve.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- tick  in  1  game-update strobe, one cycle wide
- start  in  1  level; starts or restarts a game
- pad1_y  in  Y_W  top edge of the player-1 paddle
- pad2_y  in  Y_W  top edge of the player-2 paddle
- ball_x  out  X_W  left edge of the ball
- ball_y  out  Y_W  top edge of the ball
- score1  out  SCORE_W  player-1 score
- score2  out  SCORE_W  player-2 score
- game_over  out  1  high while in OVER
- hit  out  1  one-cycle pulse on a paddle hit
- point  out  1  one-cycle pulse when a point is scored
- state_o  out  3  current FSM state encoding, for the SSD

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (reset=0) forces:
  - state = IDLE
  - ball at centre: CX = (SCREEN_W-BALL_SIZE)/2, CY = (SCREEN_H-BALL_SIZE)/2
  - scores = 0
  - dir_x = right, dir_y = down
  - both speeds = INIT_SPEED
  - hit = point = game_over = 0
- Reset mid-operation aborts any in-flight update. No partial score is kept.
- State encodings: IDLE=0, SERVE=1, PLAY=2, UPDATE=3, COLLIDE=4, OVER=5.
- IDLE: ball held at centre. When start=1, clear both scores and go to SERVE with serve counter = 0.
- SERVE: the counter increments on each tick. When the counter reaches SERVE_TICKS-1 and a tick arrives, go to PLAY.
- PLAY: on a tick, go to UPDATE. Ticks that arrive while in UPDATE or COLLIDE are ignored, so at most one move per tick.
- UPDATE (1 cycle): move the ball, clamping at the edges.
  - X moving left: if ball_x <= spd_x then x = 0, else x = ball_x - spd_x.
  - X moving right: x = min(ball_x + spd_x, SCREEN_W-BALL_SIZE).
  - Y uses the same rule against 0 and SCREEN_H-BALL_SIZE.
  - Sums are computed one bit wider than the operands, so there is no wrap-around.
  - pad1_y and pad2_y are sampled in this cycle.
- COLLIDE (1 cycle): checks in priority order. The result is visible on the outputs in the cycle after COLLIDE.
  1. Top/bottom wall. If y = 0, set dir_y = down. If y = SCREEN_H-BALL_SIZE, set dir_y = up.
  2. Paddle 1, checked only while moving left. Condition: ball_x <= PAD1_X+PAD_W, ball_x+BALL_SIZE > PAD1_X, ball_y+BALL_SIZE > pad1_y, and ball_y < pad1_y+PAD_H. Response:
     - dir_x = right and ball_x = PAD1_X+PAD_W.
     - spd_x = min(spd_x+1, MAX_SPEED).
     - dir_y = up if the ball centre is above the paddle centre, else down.
     - hit pulses.
  3. Paddle 2 mirrors paddle 1. It is checked only while moving right, and the ball is snapped to ball_x = PAD2_X-BALL_SIZE.
  4. Goal, only if no paddle hit this cycle:
     - x = 0 scores a point for player 2.
     - x = SCREEN_W-BALL_SIZE scores a point for player 1.
     - point pulses; the score increments, saturating at WIN_SCORE.
- After a goal:
  - If the new score equals WIN_SCORE, go to OVER.
  - Otherwise recentre the ball, reset both speeds to INIT_SPEED, set dir_x toward the player who conceded, clear the serve counter, and go to SERVE.
- After a paddle hit or no event, return to PLAY.
- A wall event and a paddle event in the same COLLIDE both apply.
- A corner contact (x=0 and y=0) reflects Y and also scores the goal.
- OVER: game_over=1, the ball is frozen and the scores are held. start=1 goes to IDLE, then to SERVE on the next cycle with scores cleared.
- start is ignored in every state except IDLE and OVER.

Test Plan:
- Reset, then start=1 and 32 ticks -> SERVE then PLAY. First tick gives ball_x 315->317 and ball_y 235->237.
- Ball moving left at spd_x=2, ball_x=31, pad1_y=200, ball_y=220, one tick -> ball_x=30, dir_x right, spd_x=3, hit pulses for exactly one cycle.
- Same approach with pad1_y=0 and ball_y=300 -> x clamps to 0, point pulses, score2=1, ball recentred at (315,235), dir_x left, spd_x=2.
- Ball at ball_y=1, moving up at speed 2 -> ball_y=0 and dir_y down; next tick ball_y=2.
- score1=8, then player-1 goal -> score1=9, game_over=1. Further ticks leave the ball unchanged; start=1 clears the scores.
- Assert reset during UPDATE with a goal imminent -> state IDLE, scores 0, no point pulse. Also send two ticks one cycle apart -> only one move occurs.
